// File: rtl/fbuf_bank_manager.sv
// Triple/double-buffer bank arbiter between a camera write path and a display read path.
// Hands out SDRAM frame banks so the writer never overwrites the bank being read.
module fbuf_bank_manager #(
  parameter int NUM_BANKS   = 3,
  parameter int ADDR_W      = 20,
  parameter int FRAME_WORDS = 130560,
  parameter int LOAD_CYC    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              frame_valid,
  input  logic              frame_write_done,
  input  logic              frame_read_done,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic              wr_load,
  output logic              rd_load,
  output logic [ADDR_W+1:0] wr_addr,
  output logic [ADDR_W+1:0] wr_max_addr,
  output logic [ADDR_W+1:0] rd_addr,
  output logic [ADDR_W+1:0] rd_max_addr,
  output logic              frame_dropped,
  output logic              frame_repeated,
  output logic              frame_aborted,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       repeat_cnt
);

  typedef enum logic [1:0] {W_INIT, W_IDLE, W_LOAD, W_ACTIVE} wrState_e;
  typedef enum logic [1:0] {R_INIT, R_RUN, R_LOAD} rdState_e;

  localparam logic [3:0]        LOAD_LAST = 4'(LOAD_CYC - 1);
  localparam logic [ADDR_W-1:0] FRAME_LIM = ADDR_W'(FRAME_WORDS);

  logic [1:0]  rstSync_q;
  logic        rstInt_n;
  logic [2:0]  fvSync_q;
  logic        frameStart;

  wrState_e    wrState_q, wrState_d;
  rdState_e    rdState_q, rdState_d;
  logic [3:0]  wrCnt_q, wrCnt_d;
  logic [3:0]  rdCnt_q, rdCnt_d;
  logic [1:0]  wrBank_q, wrBank_d;
  logic [1:0]  rdBank_q, rdBank_d;
  logic [1:0]  readyBank_q, readyBank_d;
  logic        readyValid_q, readyValid_d;
  logic        dropped_q, dropped_d;
  logic        repeated_q, repeated_d;
  logic        aborted_q, aborted_d;
  logic [15:0] dropCnt_q, dropCnt_d;
  logic [15:0] repeatCnt_q, repeatCnt_d;
  logic        freeFound;
  logic [1:0]  freeBank;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstSync_q <= 2'b00;
    else        rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstInt_n   = rstSync_q[1];
  assign frameStart = fvSync_q[1] & ~fvSync_q[2];

  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      fvSync_q     <= 3'b000;
      wrState_q    <= W_INIT;
      rdState_q    <= R_INIT;
      wrCnt_q      <= 4'd0;
      rdCnt_q      <= 4'd0;
      wrBank_q     <= 2'd0;
      rdBank_q     <= 2'd1;
      readyBank_q  <= 2'd0;
      readyValid_q <= 1'b0;
      dropped_q    <= 1'b0;
      repeated_q   <= 1'b0;
      aborted_q    <= 1'b0;
      dropCnt_q    <= 16'd0;
      repeatCnt_q  <= 16'd0;
    end else begin
      fvSync_q     <= {fvSync_q[1:0], frame_valid};
      wrState_q    <= wrState_d;
      rdState_q    <= rdState_d;
      wrCnt_q      <= wrCnt_d;
      rdCnt_q      <= rdCnt_d;
      wrBank_q     <= wrBank_d;
      rdBank_q     <= rdBank_d;
      readyBank_q  <= readyBank_d;
      readyValid_q <= readyValid_d;
      dropped_q    <= dropped_d;
      repeated_q   <= repeated_d;
      aborted_q    <= aborted_d;
      dropCnt_q    <= dropCnt_d;
      repeatCnt_q  <= repeatCnt_d;
    end
  end

  // Lowest bank not being displayed and not holding an unconsumed frame.
  always_comb begin
    freeFound = 1'b0;
    freeBank  = 2'd0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if ((2'(i) != rdBank_q) && !(readyValid_q && (2'(i) == readyBank_q))) begin
        freeFound = 1'b1;
        freeBank  = 2'(i);
      end
    end
  end

  always_comb begin
    wrState_d    = wrState_q;
    rdState_d    = rdState_q;
    wrCnt_d      = wrCnt_q;
    rdCnt_d      = rdCnt_q;
    wrBank_d     = wrBank_q;
    rdBank_d     = rdBank_q;
    readyBank_d  = readyBank_q;
    readyValid_d = readyValid_q;
    dropped_d    = 1'b0;
    repeated_d   = 1'b0;
    aborted_d    = 1'b0;
    dropCnt_d    = dropCnt_q;
    repeatCnt_d  = repeatCnt_q;

    case (wrState_q)
      W_INIT: if (init_done) wrState_d = W_IDLE;
      W_IDLE: begin
        if (frameStart) begin
          if (freeFound) begin
            wrBank_d  = freeBank;
            wrCnt_d   = LOAD_LAST;
            wrState_d = W_LOAD;
          end else begin
            dropped_d = 1'b1;
            dropCnt_d = dropCnt_q + 16'd1;
          end
        end
      end
      W_LOAD: begin
        if (frameStart) begin
          aborted_d = 1'b1;
          wrCnt_d   = LOAD_LAST;
        end else if (wrCnt_q == 4'd0) begin
          wrState_d = W_ACTIVE;
        end else begin
          wrCnt_d = wrCnt_q - 4'd1;
        end
      end
      W_ACTIVE: begin
        if (frameStart) begin
          aborted_d = 1'b1;
          wrCnt_d   = LOAD_LAST;
          wrState_d = W_LOAD;
        end else if (frame_write_done) begin
          readyBank_d  = wrBank_q;
          readyValid_d = 1'b1;
          wrState_d    = W_IDLE;
          if (readyValid_q) begin
            dropped_d = 1'b1;
            dropCnt_d = dropCnt_q + 16'd1;
          end
        end
      end
      default: wrState_d = W_INIT;
    endcase

    // Reader sees the writer's update from this same clock.
    case (rdState_q)
      R_INIT: begin
        if (init_done) begin
          rdCnt_d   = LOAD_LAST;
          rdState_d = R_LOAD;
        end
      end
      R_RUN: begin
        if (frame_read_done) begin
          if (readyValid_d) begin
            rdBank_d     = readyBank_d;
            readyValid_d = 1'b0;
          end else begin
            repeated_d  = 1'b1;
            repeatCnt_d = repeatCnt_q + 16'd1;
          end
          rdCnt_d   = LOAD_LAST;
          rdState_d = R_LOAD;
        end
      end
      R_LOAD: begin
        if (rdCnt_q == 4'd0) rdState_d = R_RUN;
        else                 rdCnt_d   = rdCnt_q - 4'd1;
      end
      default: rdState_d = R_INIT;
    endcase

    if (!init_done) begin
      wrState_d    = W_INIT;
      rdState_d    = R_INIT;
      readyValid_d = 1'b0;
      wrBank_d     = wrBank_q;
      rdBank_d     = rdBank_q;
      readyBank_d  = readyBank_q;
      dropped_d    = 1'b0;
      repeated_d   = 1'b0;
      aborted_d    = 1'b0;
      dropCnt_d    = dropCnt_q;
      repeatCnt_d  = repeatCnt_q;
    end
  end

  assign wr_bank        = wrBank_q;
  assign rd_bank        = rdBank_q;
  assign wr_load        = (wrState_q == W_LOAD);
  assign rd_load        = (rdState_q == R_LOAD);
  assign wr_addr        = {wrBank_q, {ADDR_W{1'b0}}};
  assign wr_max_addr    = {wrBank_q, FRAME_LIM};
  assign rd_addr        = {rdBank_q, {ADDR_W{1'b0}}};
  assign rd_max_addr    = {rdBank_q, FRAME_LIM};
  assign frame_dropped  = dropped_q;
  assign frame_repeated = repeated_q;
  assign frame_aborted  = aborted_q;
  assign drop_cnt       = dropCnt_q;
  assign repeat_cnt     = repeatCnt_q;

endmodule
